// File: rtl/audio_serial_tx.sv
// Serial audio transmitter: register-programmed FIFO of stereo pairs shifted out as
// left-justified 32-bit-per-channel frames with bit clock, LR sync and low-water request.
module audio_serial_tx #(
  parameter int unsigned CLKDIV    = 16,
  parameter int unsigned FIFODEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic [3:0]  i_addr,
  input  logic [15:0] i_data_wr,
  output logic [15:0] o_data_rd,
  input  logic        i_en,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic        o_abit_clk,
  output logic        o_async,
  output logic        o_asdo,
  output logic        o_irq
);

  localparam int unsigned PtrW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int unsigned LvlW = $clog2(FIFODEPTH + 1);
  localparam int unsigned DivW = 8;

  logic              r_enable;
  logic              r_mute;
  logic [15:0]       r_left;
  logic              r_underrun;
  logic              r_overflow;
  logic [31:0]       r_mem [FIFODEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [LvlW-1:0]   r_level;
  logic              r_irq;

  logic [DivW-1:0]   r_div;
  logic              r_abit;
  logic [5:0]        r_bit_idx;
  logic              r_async;
  logic              r_asdo;
  logic [31:0]       r_shift_l;
  logic [31:0]       r_shift_r;

  logic              w_wr_ctrl;
  logic              w_wr_left;
  logic              w_push;
  logic              w_wr_stat;
  logic              w_full;
  logic              w_empty;
  logic              w_enable_nxt;
  logic              w_tick;
  logic              w_fall;
  logic [5:0]        w_bit_nxt;
  logic              w_frame;
  logic              w_pop;
  logic              w_push_ok;
  logic [31:0]       w_head;
  logic [31:0]       w_load_l;
  logic [31:0]       w_load_r;
  logic [4:0]        w_level5;
  logic              w_rd_unused;

  assign w_wr_ctrl = i_en & i_wr & (i_addr == 4'd0);
  assign w_wr_left = i_en & i_wr & (i_addr == 4'd1);
  assign w_push    = i_en & i_wr & (i_addr == 4'd2);
  assign w_wr_stat = i_en & i_wr & (i_addr == 4'd3);

  assign w_full  = (r_level == LvlW'(FIFODEPTH));
  assign w_empty = (r_level == '0);

  // Serial engine follows the enable value being written so a disable takes effect at once.
  assign w_enable_nxt = w_wr_ctrl ? i_data_wr[0] : r_enable;
  assign w_tick       = r_enable & w_enable_nxt & (r_div == DivW'(CLKDIV - 1));
  assign w_fall       = w_tick & r_abit;
  assign w_bit_nxt    = r_bit_idx + 6'd1;
  assign w_frame      = w_fall & (w_bit_nxt == 6'd0);
  assign w_pop        = w_frame & ~w_empty;
  assign w_push_ok    = w_push & ~w_full;

  assign w_head   = r_mem[r_rptr];
  assign w_load_l = (w_pop & ~r_mute) ? {w_head[31:16], 16'h0} : 32'h0;
  assign w_load_r = (w_pop & ~r_mute) ? {w_head[15:0], 16'h0} : 32'h0;
  assign w_level5 = 5'(r_level);

  // Read strobe carries no side effects; reads are purely combinational.
  assign w_rd_unused = i_rd;

  always_comb begin
    o_data_rd = 16'h0;
    case (i_addr)
      4'd0:    o_data_rd = {14'h0, r_mute, r_enable};
      4'd1:    o_data_rd = r_left;
      4'd3:    o_data_rd = {3'b000, w_level5, 4'h0, r_overflow, r_underrun, w_full, w_empty};
      default: o_data_rd = 16'h0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_enable <= 1'b0;
      r_mute   <= 1'b0;
      r_left   <= 16'h0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= i_data_wr[0];
        r_mute   <= i_data_wr[1];
      end
      if (w_wr_left) begin
        r_left <= i_data_wr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= {r_left, i_data_wr};
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push & w_full) begin
        r_overflow <= 1'b1;
      end else if (w_wr_stat & i_data_wr[3]) begin
        r_overflow <= 1'b0;
      end
      if (w_frame & w_empty) begin
        r_underrun <= 1'b1;
      end else if (w_wr_stat & i_data_wr[2]) begin
        r_underrun <= 1'b0;
      end
      r_irq <= r_enable & (r_level < LvlW'(FIFODEPTH / 2));
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_div     <= '0;
      r_abit    <= 1'b0;
      r_bit_idx <= 6'd63;
      r_async   <= 1'b0;
      r_asdo    <= 1'b0;
      r_shift_l <= 32'h0;
      r_shift_r <= 32'h0;
    end else if (!w_enable_nxt) begin
      r_div     <= '0;
      r_abit    <= 1'b0;
      r_bit_idx <= 6'd63;
      r_async   <= 1'b0;
      r_asdo    <= 1'b0;
    end else if (r_enable) begin
      if (w_tick) begin
        r_div  <= '0;
        r_abit <= ~r_abit;
        if (w_fall) begin
          r_bit_idx <= w_bit_nxt;
          r_async   <= w_bit_nxt[5];
          if (w_frame) begin
            r_asdo    <= w_load_l[31];
            r_shift_l <= {w_load_l[30:0], 1'b0};
            r_shift_r <= w_load_r;
          end else if (!w_bit_nxt[5]) begin
            r_asdo    <= r_shift_l[31];
            r_shift_l <= {r_shift_l[30:0], 1'b0};
          end else begin
            r_asdo    <= r_shift_r[31];
            r_shift_r <= {r_shift_r[30:0], 1'b0};
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_abit_clk = r_abit;
  assign o_async    = r_async;
  assign o_asdo     = r_asdo;
  assign o_irq      = r_irq;

endmodule

// File: tb/tb_audio_serial_tx.sv
// Directed bench for audio_serial_tx (CLKDIV=2, FIFODEPTH=4): register map, frame
// serialisation, underrun/overflow, mid-frame disable and mid-frame reset.
module tb_audio_serial_tx;

  logic        clk;
  logic        resetn;
  logic [3:0]  i_addr;
  logic [15:0] i_data_wr;
  logic [15:0] o_data_rd;
  logic        i_en;
  logic        i_rd;
  logic        i_wr;
  logic        o_abit_clk;
  logic        o_async;
  logic        o_asdo;
  logic        o_irq;

  int n_checks = 0;
  int n_errors = 0;

  audio_serial_tx #(
    .CLKDIV   (2),
    .FIFODEPTH(4)
  ) dut (
    .i_clk     (clk),
    .i_resetn  (resetn),
    .i_addr    (i_addr),
    .i_data_wr (i_data_wr),
    .o_data_rd (o_data_rd),
    .i_en      (i_en),
    .i_rd      (i_rd),
    .i_wr      (i_wr),
    .o_abit_clk(o_abit_clk),
    .o_async   (o_async),
    .o_asdo    (o_asdo),
    .o_irq     (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
    i_en = 1'b1; i_wr = 1'b1; i_addr = a; i_data_wr = d;
    @(negedge clk);
    i_en = 1'b0; i_wr = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    i_addr = a; i_rd = 1'b1;
    #1;
    d = o_data_rd;
    i_rd = 1'b0;
    check(tag, {48'h0, d}, {48'h0, exp});
  endtask

  // Waits for the next AbitClk rising edge and returns the bit the receiver samples there.
  task automatic get_bit(output logic d, output logic s, output int waited);
    logic prev;
    logic found;
    prev = o_abit_clk; found = 1'b0; waited = 0; d = 1'b0; s = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      waited++;
      if (o_abit_clk && !prev) begin
        d = o_asdo; s = o_async; found = 1'b1;
        break;
      end
      prev = o_abit_clk;
    end
    if (!found) check("abit_timeout", 64'(waited), 64'd0);
  endtask

  task automatic get_bits(input int n, output logic [63:0] data, output logic [63:0] sync,
                          output int first_wait);
    logic d, s;
    int w;
    data = '0; sync = '0; first_wait = 0;
    for (int i = 0; i < n; i++) begin
      get_bit(d, s, w);
      if (i == 0) first_wait = w;
      data = {data[62:0], d};
      sync = {sync[62:0], s};
    end
  endtask

  logic [63:0] data, sync;
  logic        bd, bs;
  int          fw, rises;
  logic        prev_abit;

  initial begin
    resetn = 1'b1; i_addr = 4'd0; i_data_wr = 16'h0; i_en = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("rst_abit", {63'h0, o_abit_clk}, 64'h0);
    check("rst_async", {63'h0, o_async}, 64'h0);
    check("rst_asdo", {63'h0, o_asdo}, 64'h0);
    check("rst_irq", {63'h0, o_irq}, 64'h0);
    check_reg("rst_status", 4'd3, 16'h0001);
    check_reg("rst_ctrl", 4'd0, 16'h0000);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Single pair then an empty frame.
    bus_wr(4'd1, 16'hA5C3);
    check_reg("left_rb", 4'd1, 16'hA5C3);
    bus_wr(4'd2, 16'h1234);
    check_reg("right_rd0", 4'd2, 16'h0000);
    check_reg("status_l1", 4'd3, 16'h0100);
    bus_wr(4'd0, 16'h0001);
    check_reg("ctrl_en", 4'd0, 16'h0001);
    get_bit(bd, bs, fw);
    get_bits(64, data, sync, fw);
    check("abit_period", 64'(fw), 64'd4);
    check("frame1_data", data, 64'hA5C3_0000_1234_0000);
    check("frame1_sync", sync, 64'h0000_0000_FFFF_FFFF);
    check_reg("status_after1", 4'd3, 16'h0001);
    get_bits(64, data, sync, fw);
    check("empty_data", data, 64'h0);
    check("empty_sync", sync, 64'h0000_0000_FFFF_FFFF);
    check_reg("status_under", 4'd3, 16'h0005);
    check("irq_low_level", {63'h0, o_irq}, 64'h1);
    bus_wr(4'd0, 16'h0000);
    bus_wr(4'd3, 16'h0004);
    check_reg("status_clr_under", 4'd3, 16'h0001);
    check("dis_abit", {63'h0, o_abit_clk}, 64'h0);
    check("irq_disabled", {63'h0, o_irq}, 64'h0);

    // Five pushes into a depth-4 FIFO: last one dropped.
    for (int n = 1; n <= 5; n++) begin
      bus_wr(4'd1, 16'(n));
      bus_wr(4'd2, 16'(16'h0100 + n));
    end
    check_reg("status_full_ovf", 4'd3, 16'h040A);
    bus_wr(4'd0, 16'h0001);
    get_bit(bd, bs, fw);
    for (int n = 1; n <= 4; n++) begin
      get_bits(64, data, sync, fw);
      check($sformatf("fifo_frame%0d", n), data,
            {16'(n), 16'h0, 16'(16'h0100 + n), 16'h0});
    end
    get_bits(64, data, sync, fw);
    check("pair5_not_sent", data, 64'h0);
    check_reg("status_under_ovf", 4'd3, 16'h000D);
    bus_wr(4'd0, 16'h0000);
    bus_wr(4'd3, 16'h000C);
    check_reg("status_clr_both", 4'd3, 16'h0001);

    // Disable at BitIndex 20, then re-enable with the next pair.
    bus_wr(4'd1, 16'h1111); bus_wr(4'd2, 16'h2222);
    bus_wr(4'd1, 16'h3333); bus_wr(4'd2, 16'h4444);
    check_reg("status_l2", 4'd3, 16'h0200);
    bus_wr(4'd0, 16'h0001);
    get_bit(bd, bs, fw);
    get_bits(21, data, sync, fw);
    check("partial_a", data, {43'h0, 16'h1111, 5'h0});
    check("abit_high_b20", {63'h0, o_abit_clk}, 64'h1);
    bus_wr(4'd0, 16'h0000);
    check("middis_abit", {63'h0, o_abit_clk}, 64'h0);
    check("middis_async", {63'h0, o_async}, 64'h0);
    check("middis_asdo", {63'h0, o_asdo}, 64'h0);
    check_reg("status_a_gone", 4'd3, 16'h0100);
    bus_wr(4'd0, 16'h0001);
    get_bit(bd, bs, fw);
    get_bits(64, data, sync, fw);
    check("frame_b", data, 64'h3333_0000_4444_0000);
    check("frame_b_sync", sync, 64'h0000_0000_FFFF_FFFF);

    // Reset at BitIndex 40.
    bus_wr(4'd0, 16'h0000);
    bus_wr(4'd1, 16'hC0DE); bus_wr(4'd2, 16'hFFFF);
    bus_wr(4'd0, 16'h0001);
    get_bit(bd, bs, fw);
    get_bits(41, data, sync, fw);
    check("partial_c", data, {23'h0, 16'hC0DE, 16'h0, 9'h1FF});
    resetn = 1'b0;
    #1;
    check("midrst_abit", {63'h0, o_abit_clk}, 64'h0);
    check("midrst_async", {63'h0, o_async}, 64'h0);
    check("midrst_asdo", {63'h0, o_asdo}, 64'h0);
    check("midrst_irq", {63'h0, o_irq}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    check_reg("midrst_status", 4'd3, 16'h0001);
    check_reg("midrst_ctrl", 4'd0, 16'h0000);
    check_reg("midrst_left", 4'd1, 16'h0000);
    rises = 0;
    prev_abit = o_abit_clk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_abit_clk && !prev_abit) rises++;
      prev_abit = o_abit_clk;
    end
    check("no_abit_after_rst", 64'(rises), 64'd0);
    bus_wr(4'd0, 16'h0001);
    get_bit(bd, bs, fw);
    check("restart_latency", 64'(fw), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
